// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words (MSB first) from a
// qualified serial bit stream, strobes each finished word and drops partial
// words that stall for TIMEOUT cycles.
module serie_paralelo #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena_in,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             ena_out,
    output logic             err
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [IW-1:0] TLIM = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] TMAX = IW'(TIMEOUT);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idle, idle_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] out_n;
    logic             done_n, err_n;
    logic [WIDTH-1:0] sh_shift;

    // The shift register always holds the most recent WIDTH sampled bits, so a
    // finished word is simply the shifted value; stale bits fall off the top.
    assign sh_shift = WIDTH'({sh, in});

    // State, counters, data and registered strobes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            idle    <= '0;
            sh      <= '0;
            out     <= '0;
            ena_out <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idle    <= idle_n;
            sh      <= sh_n;
            out     <= out_n;
            ena_out <= done_n;
            err     <= err_n;
        end
    end

    // Next-state logic: sample on ena_in, complete words, track stall time.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idle_n  = idle;
        sh_n    = sh;
        out_n   = out;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                idle_n = '0;
                if (ena_in) begin
                    sh_n = sh_shift;
                    if (WIDTH == 1) begin
                        out_n  = sh_shift;
                        done_n = 1'b1;
                    end else begin
                        cnt_n   = CW'(1);
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (ena_in) begin
                    sh_n   = sh_shift;
                    idle_n = '0;
                    if (cnt == LAST) begin
                        out_n   = sh_shift;
                        done_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else if (idle == TLIM) begin
                    cnt_n   = '0;
                    idle_n  = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (idle != TMAX) begin
                    idle_n = idle + IW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serie_paralelo.sv
// Bench for serie_paralelo: directed scenarios plus random bit/gap traffic,
// compared every cycle against a queue-based word assembler model.
module tb_serie_paralelo;

    localparam int W  = 6;
    localparam int TO = 15;

    logic         clk;
    logic         clr;
    logic         ena_in;
    logic         din;
    logic [W-1:0] dout;
    logic         ena_out;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           q[$];
    int           gap;
    logic [W-1:0] m_out;
    logic         m_ena;
    logic         m_err;

    serie_paralelo #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .clr     (clr),
        .ena_in  (ena_in),
        .in      (din),
        .out     (dout),
        .ena_out (ena_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        gap   = 0;
        m_out = '0;
        m_ena = 1'b0;
        m_err = 1'b0;
    endtask

    // Apply one cycle of input, advance the model, then compare all outputs.
    task automatic step(input logic e, input logic b, input string tag);
        logic [W-1:0] w;
        ena_in = e;
        din    = b;
        @(posedge clk);
        m_ena = 1'b0;
        m_err = 1'b0;
        if (e) begin
            q.push_back(b);
            gap = 0;
            if (q.size() == W) begin
                w = '0;
                foreach (q[i]) w = {w[W-2:0], q[i]};
                m_out = w;
                m_ena = 1'b1;
                q.delete();
            end
        end else if (q.size() > 0) begin
            gap++;
            if (gap == TO) begin
                q.delete();
                gap   = 0;
                m_err = 1'b1;
            end
        end
        #1;
        check({tag, "_out"}, dout, m_out);
        check({tag, "_ena"}, ena_out, m_ena);
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input string tag);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), tag);
    endtask

    initial begin
        clr    = 1'b1;
        ena_in = 1'b0;
        din    = 1'b0;
        model_reset();
        #1;
        check("rst_out", dout, 0);
        check("rst_ena", ena_out, 0);
        check("rst_err", err, 0);
        #12;
        clr = 1'b0;
        @(negedge clk);

        // Single word 101101
        send_bits(32'b101101, 6, "t2");
        check("t2_word", dout, 6'h2D);
        check("t2_strobe", ena_out, 1);
        step(1'b0, 1'b0, "t2_after");
        check("t2_strobe_drop", ena_out, 0);

        // Back-to-back words
        send_bits(32'b111000, 6, "t3a");
        check("t3_word_a", dout, 6'h38);
        send_bits(32'b010101, 6, "t3b");
        check("t3_word_b", dout, 6'h15);
        check("t3_strobe_b", ena_out, 1);

        // Gaps of 3 cycles between bits
        for (int i = 5; i >= 0; i--) begin
            logic [5:0] v;
            v = 6'b110011;
            step(1'b1, v[i], "t4");
            if (i != 0) idle_cycles(3, "t4_gap");
        end
        check("t4_word", dout, 6'h33);

        // Timeout after 3 bits, then a fresh word
        send_bits(32'b101, 3, "t5");
        idle_cycles(TO - 1, "t5_gap");
        check("t5_no_err_yet", err, 0);
        step(1'b0, 1'b1, "t5_to");
        check("t5_err", err, 1);
        check("t5_out_kept", dout, 6'h33);
        send_bits(32'b000111, 6, "t5b");
        check("t5_word", dout, 6'h07);

        // Edge race: bit lands on the last idle edge before timeout
        send_bits(32'b110, 3, "t6");
        idle_cycles(TO - 1, "t6_gap");
        send_bits(32'b001, 3, "t6b");
        check("t6_word", dout, 6'h31);
        check("t6_no_err", err, 0);

        // Reset mid-word, then a fresh word
        send_bits(32'b1111, 4, "t1");
        #2;
        clr = 1'b1;
        #1;
        check("t1_out", dout, 0);
        check("t1_ena", ena_out, 0);
        check("t1_err", err, 0);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        #1;
        send_bits(32'b100110, 6, "t1b");
        check("t1_word", dout, 6'h26);

        // Random traffic with short gaps and occasional long stalls
        for (int n = 0; n < 300; n++) begin
            int g;
            g = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 18))
                                            : int'($urandom_range(0, 2));
            idle_cycles(g, "rnd_gap");
            step(1'b1, 1'($urandom), "rnd");
        end
        idle_cycles(TO + 2, "rnd_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
